player_motion_engine: RTL and testbench
=======================================

PLAYER_MOTION_ENGINE -- requirements
Module: player_motion_engine

Interface
REQ-001 SHALL have parameters (name, default, meaning): INITIAL_X 280 reset X pixel; INITIAL_Y 185 reset Y pixel; FP_SHIFT 6 fixed-point fraction bits; X_SPEED 200 walk speed; JUMP_SPEED 300 jump speed; CLIMB_SPEED 100 rope speed; GRAVITY 10 per-frame accel; MAX_FALL 230 fall-speed cap; MAX_JUMPS 2 jumps per airtime (1..7); STUN_FRAMES 30 stun length; X_MIN -9, X_MAX 570 pixel X limits.
REQ-002 SHALL have ports (name direction width meaning): clk in 1 clock; resetN in 1 async active-low reset; startOfFrame in 1 one-cycle frame pulse; leftPressed/rightPressed/upPressed/downPressed in 1 each key levels; collision in 1 any overlap; onRope in 1 overlapping rope; objectHit in 1 hit by hazard; HitEdgeCode in 4 edge bits [3]=left,[2]=bottom,[1]=right,[0]=top; topLeftX out 11 signed pixel X; topLeftY out 11 signed pixel Y; motionState out 2 current state; jumpsLeft out 3 remaining jumps; stunned out 1 high in STUNNED.
REQ-003 SHALL use one clock, clk; reset resetN is asynchronous and active-low.

Function
REQ-004 SHALL hold X, Y positions and Xspeed, Yspeed as 32-bit signed values scaled by 2^FP_SHIFT; outputs = position arithmetic-shifted right by FP_SHIFT (floor), low 11 bits.
REQ-005 SHALL change state, speeds, positions and jump count only in the clk cycle where startOfFrame=1; all outputs registered, visible the following cycle.
REQ-006 SHALL latch any rising edge of upPressed between frames (jumpReq); jumpReq cleared at each startOfFrame after use; a held key yields exactly one request.
REQ-007 SHALL derive ledge = collision & HitEdgeCode[2] & !objectHit; footing = ledge | onRope.
REQ-008 SHALL implement states GROUNDED(0), CLIMBING(1), AIRBORNE(2), STUNNED(3); transition priority per frame: objectHit -> STUNNED; onRope -> CLIMBING; ledge -> GROUNDED; else AIRBORNE.
REQ-009 GROUNDED: Yspeed=0, jumpsLeft=MAX_JUMPS; jumpReq -> Yspeed=-JUMP_SPEED, jumpsLeft=MAX_JUMPS-1, next state AIRBORNE.
REQ-010 CLIMBING: Yspeed = -CLIMB_SPEED if upPressed, +CLIMB_SPEED if downPressed only, else 0; jumpsLeft=MAX_JUMPS; no gravity.
REQ-011 AIRBORNE: Yspeed += GRAVITY, saturated at MAX_FALL; jumpReq with jumpsLeft>0 -> Yspeed=-JUMP_SPEED, jumpsLeft-1; jumpReq with jumpsLeft=0 ignored.
REQ-012 Ceiling: collision & HitEdgeCode[0] & Yspeed<0 -> Yspeed=0 that frame.
REQ-013 Xspeed = +X_SPEED if rightPressed only, -X_SPEED if leftPressed only, 0 if both or neither; forced 0 toward a wall (collision & HitEdgeCode[1] blocks +, HitEdgeCode[3] blocks -).
REQ-014 Position update X += Xspeed, Y += Yspeed using the speeds computed this frame; X clamped to [X_MIN, X_MAX]·2^FP_SHIFT.
REQ-015 STUNNED: Xspeed=0, keys and jumpReq ignored, gravity applies, objectHit ignored; stun counter loads STUN_FRAMES-1 on entry, decrements per frame; at 0 next state per REQ-008 excluding objectHit re-entry that frame.
REQ-016 jumpsLeft SHALL never underflow or exceed MAX_JUMPS.

Reset
REQ-017 On resetN=0: X=INITIAL_X·2^FP_SHIFT, Y=INITIAL_Y·2^FP_SHIFT, speeds 0, state AIRBORNE, jumpsLeft=MAX_JUMPS, stun counter 0, jumpReq 0, stunned 0.
REQ-018 Reset mid-jump or mid-stun SHALL discard all motion immediately; no output glitch after release other than REQ-017 values.

Structure
REQ-019 SHALL place state enum, HitEdgeCode bit-index constants and FP_SHIFT default in shared package motion_pkg.
REQ-020 SHALL instantiate one sub-module key_edge_latch (rising-edge capture, clear on startOfFrame) for upPressed.

Verification
REQ-021 Reset, no footing, 10 frames -> Yspeed 10,20..100; topLeftY=185+floor(550/64)=193.
REQ-022 Ledge held, one up tap -> AIRBORNE, Yspeed=-300, jumpsLeft=1; second tap -> Yspeed=-300, jumpsLeft=0; third tap -> no change.
REQ-023 Airborne 40 frames -> Yspeed saturates at 230, never exceeds.
REQ-024 rightPressed held from X=565 for 10 frames -> topLeftX stops at 570; left+right together -> X unchanged.
REQ-025 objectHit one frame -> stunned=1 for exactly 30 frames, X constant, keys ignored, then state per footing.
REQ-026 onRope with upPressed 64 frames -> topLeftY decreases by 100; up tap on rope does not change jumpsLeft.

Source files
------------

// File: rtl/motion_pkg.sv
// Purpose : shared types and constants for the player motion engine.
// Latency : n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   motionState_t     - GROUNDED / CLIMBING / AIRBORNE / STUNNED, encoded 0..3
//   EDGE_*            - bit positions inside HitEdgeCode
//   FP_SHIFT_DEFAULT  - default number of fixed-point fraction bits
//   applyGravity()    - one frame of gravity with a fall-speed cap
package motion_pkg;

  typedef enum logic [1:0] {
    GROUNDED = 2'd0,
    CLIMBING = 2'd1,
    AIRBORNE = 2'd2,
    STUNNED  = 2'd3
  } motionState_t;

  // HitEdgeCode bit positions: [3]=left, [2]=bottom, [1]=right, [0]=top.
  localparam int EDGE_LEFT   = 3;
  localparam int EDGE_BOTTOM = 2;
  localparam int EDGE_RIGHT  = 1;
  localparam int EDGE_TOP    = 0;

  localparam int FP_SHIFT_DEFAULT = 6;

  // Adds one frame of gravity. Only downward speed is capped, so a fresh
  // jump (large negative speed) decays naturally towards the cap.
  function automatic logic signed [31:0] applyGravity(
    input logic signed [31:0] speed,
    input int                 gravity,
    input int                 maxFall
  );
    logic signed [31:0] sum;
    sum = speed + gravity;
    if (sum > maxFall) begin
      sum = maxFall;
    end
    return sum;
  endfunction

endpackage

// File: rtl/key_edge_latch.sv
// Purpose : captures a rising edge of a key level and holds it as a request.
// Latency : request visible the cycle after the edge; cleared by clearReq.
// Backpressure: none; the request is held until the next clearReq.
//
// Ports:
//   clk, resetN - clock, async active-low reset
//   keyLevel    - raw key level
//   clearReq    - consumer has sampled the request (frame pulse)
//   keyReq      - latched request
module key_edge_latch (
  input  logic clk,
  input  logic resetN,
  input  logic keyLevel,
  input  logic clearReq,
  output logic keyReq
);

  logic keyPrev;
  logic keyRise;

  // Edge detect against the previous cycle's level, so a key held across
  // many frames produces exactly one request.
  assign keyRise = keyLevel & ~keyPrev;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      keyPrev <= 1'b0;
      keyReq  <= 1'b0;
    end else begin
      keyPrev <= keyLevel;
      // The consumer samples keyReq in the clear cycle; an edge arriving in
      // that same cycle is kept for the following frame rather than lost.
      if (clearReq) begin
        keyReq <= keyRise;
      end else begin
        keyReq <= keyReq | keyRise;
      end
    end
  end

endmodule

// File: rtl/player_motion_engine.sv
// Purpose : per-frame player kinematics (walk, multi-jump, rope climb, stun) in fixed point.
// Latency : all state updates on the clk edge of a startOfFrame cycle; outputs visible next cycle.
// Backpressure: none; exactly one motion update per startOfFrame pulse, inputs sampled as levels.
//
// Ports:
//   clk, resetN                      - clock, async active-low reset
//   startOfFrame                     - one-cycle frame pulse, the only update point
//   left/right/up/downPressed        - key levels
//   collision, onRope, objectHit     - overlap flags for this frame
//   HitEdgeCode[3:0]                 - colliding edges: [3]=left [2]=bottom [1]=right [0]=top
//   topLeftX, topLeftY               - signed pixel position (fixed point floored, low 11 bits)
//   motionState                      - current motionState_t
//   jumpsLeft                        - jumps remaining before landing
//   stunned                          - high while in STUNNED
module player_motion_engine
  import motion_pkg::*;
#(
  parameter int INITIAL_X   = 280,
  parameter int INITIAL_Y   = 185,
  parameter int FP_SHIFT    = FP_SHIFT_DEFAULT,
  parameter int X_SPEED     = 200,
  parameter int JUMP_SPEED  = 300,
  parameter int CLIMB_SPEED = 100,
  parameter int GRAVITY     = 10,
  parameter int MAX_FALL    = 230,
  parameter int MAX_JUMPS   = 2,
  parameter int STUN_FRAMES = 30,
  parameter int X_MIN       = -9,
  parameter int X_MAX       = 570
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        leftPressed,
  input  logic        rightPressed,
  input  logic        upPressed,
  input  logic        downPressed,
  input  logic        collision,
  input  logic        onRope,
  input  logic        objectHit,
  input  logic [3:0]  HitEdgeCode,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic [1:0]  motionState,
  output logic [2:0]  jumpsLeft,
  output logic        stunned
);

  localparam int                 SCALE     = 1 << FP_SHIFT;
  localparam logic signed [31:0] X_RESET   = INITIAL_X * SCALE;
  localparam logic signed [31:0] Y_RESET   = INITIAL_Y * SCALE;
  localparam logic signed [31:0] X_LO      = X_MIN * SCALE;
  localparam logic signed [31:0] X_HI      = X_MAX * SCALE;
  localparam logic [2:0]         JUMPS_MAX = 3'(MAX_JUMPS);
  localparam logic [15:0]        STUN_LOAD = 16'(STUN_FRAMES - 1);

  // Registered motion state
  motionState_t       stateQ;
  logic signed [31:0] xPos;
  logic signed [31:0] yPos;
  logic signed [31:0] ySpeed;
  logic [15:0]        stunCnt;

  // Per-frame next values
  motionState_t       stateNext;
  logic signed [31:0] xSpeedNext;
  logic signed [31:0] ySpeedNext;
  logic signed [31:0] xSum;
  logic signed [31:0] xPosNext;
  logic [2:0]         jumpsNext;
  logic [15:0]        stunNext;
  logic               jumped;

  logic jumpReq;
  logic ledge;
  logic wallRight;
  logic wallLeft;
  logic ceiling;

  key_edge_latch upLatch (
    .clk      (clk),
    .resetN   (resetN),
    .keyLevel (upPressed),
    .clearReq (startOfFrame),
    .keyReq   (jumpReq)
  );

  // A hazard overlap never counts as standing on something.
  assign ledge     = collision & HitEdgeCode[EDGE_BOTTOM] & ~objectHit;
  assign wallRight = collision & HitEdgeCode[EDGE_RIGHT];
  assign wallLeft  = collision & HitEdgeCode[EDGE_LEFT];
  assign ceiling   = collision & HitEdgeCode[EDGE_TOP];

  // Horizontal speed carries no memory between frames: it is a pure function
  // of this frame's keys and walls, so it is computed here and not stored.
  always_comb begin
    xSpeedNext = '0;
    if (stateQ != STUNNED) begin
      if (rightPressed && !leftPressed && !wallRight) begin
        xSpeedNext = X_SPEED;
      end else if (leftPressed && !rightPressed && !wallLeft) begin
        xSpeedNext = -X_SPEED;
      end
    end
  end

  // Vertical behaviour is that of the state the player is in at the start of
  // the frame; the transition below decides the state for the next frame.
  always_comb begin
    ySpeedNext = ySpeed;
    jumpsNext  = jumpsLeft;
    jumped     = 1'b0;
    case (stateQ)
      GROUNDED: begin
        ySpeedNext = '0;
        jumpsNext  = JUMPS_MAX;
        if (jumpReq) begin
          ySpeedNext = -JUMP_SPEED;
          jumpsNext  = JUMPS_MAX - 3'd1;
          jumped     = 1'b1;
        end
      end
      CLIMBING: begin
        jumpsNext = JUMPS_MAX;
        if (upPressed) begin
          ySpeedNext = -CLIMB_SPEED;
        end else if (downPressed) begin
          ySpeedNext = CLIMB_SPEED;
        end else begin
          ySpeedNext = '0;
        end
      end
      AIRBORNE: begin
        // With no jumps left the request is simply dropped.
        if (jumpReq && (jumpsLeft != 3'd0)) begin
          ySpeedNext = -JUMP_SPEED;
          jumpsNext  = jumpsLeft - 3'd1;
          jumped     = 1'b1;
        end else begin
          ySpeedNext = applyGravity(ySpeed, GRAVITY, MAX_FALL);
        end
      end
      STUNNED: begin
        ySpeedNext = applyGravity(ySpeed, GRAVITY, MAX_FALL);
      end
      default: begin
        ySpeedNext = ySpeed;
      end
    endcase
    // Bumping a ceiling kills upward motion for this frame only.
    if (ceiling && (ySpeedNext < 0)) begin
      ySpeedNext = '0;
    end
  end

  // State transition. A running stun cannot be interrupted or re-armed; once
  // it expires the player lands wherever the footing puts them. A jump taken
  // this frame wins over a ledge that is still being touched.
  always_comb begin
    stateNext = AIRBORNE;
    stunNext  = stunCnt;
    if ((stateQ == STUNNED) && (stunCnt != 16'd0)) begin
      stateNext = STUNNED;
      stunNext  = stunCnt - 16'd1;
    end else if (objectHit && (stateQ != STUNNED)) begin
      stateNext = STUNNED;
      stunNext  = STUN_LOAD;
    end else if (onRope) begin
      stateNext = CLIMBING;
    end else if (jumped) begin
      stateNext = AIRBORNE;
    end else if (ledge) begin
      stateNext = GROUNDED;
    end else begin
      stateNext = AIRBORNE;
    end
  end

  // Horizontal clamp to the playfield; vertical is left to collisions.
  always_comb begin
    xSum = xPos + xSpeedNext;
    if (xSum < X_LO) begin
      xPosNext = X_LO;
    end else if (xSum > X_HI) begin
      xPosNext = X_HI;
    end else begin
      xPosNext = xSum;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      stateQ    <= AIRBORNE;
      xPos      <= X_RESET;
      yPos      <= Y_RESET;
      ySpeed    <= '0;
      jumpsLeft <= JUMPS_MAX;
      stunCnt   <= '0;
      stunned   <= 1'b0;
    end else if (startOfFrame) begin
      stateQ    <= stateNext;
      xPos      <= xPosNext;
      yPos      <= yPos + ySpeedNext;
      ySpeed    <= ySpeedNext;
      jumpsLeft <= jumpsNext;
      stunCnt   <= stunNext;
      stunned   <= (stateNext == STUNNED);
    end
  end

  // Floor of the fixed-point position is just the bits above the fraction.
  assign topLeftX    = xPos[FP_SHIFT +: 11];
  assign topLeftY    = yPos[FP_SHIFT +: 11];
  assign motionState = stateQ;

endmodule

// File: tb/tb_player_motion_engine.sv
module tb_player_motion_engine;

  localparam int FP   = 6;
  localparam int XS   = 200;
  localparam int JS   = 300;
  localparam int CS   = 100;
  localparam int GR   = 10;
  localparam int MF   = 230;
  localparam int MJ   = 2;
  localparam int SF   = 30;
  localparam int XMIN = -9;
  localparam int XMAX = 570;

  logic        clk          = 1'b0;
  logic        resetN       = 1'b1;
  logic        startOfFrame = 1'b0;
  logic        leftPressed  = 1'b0;
  logic        rightPressed = 1'b0;
  logic        upPressed    = 1'b0;
  logic        downPressed  = 1'b0;
  logic        collision    = 1'b0;
  logic        onRope       = 1'b0;
  logic        objectHit    = 1'b0;
  logic [3:0]  HitEdgeCode  = 4'b0000;
  logic [10:0] topLeftX;
  logic [10:0] topLeftY;
  logic [1:0]  motionState;
  logic [2:0]  jumpsLeft;
  logic        stunned;

  always #5 clk = ~clk;

  player_motion_engine dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .leftPressed  (leftPressed),
    .rightPressed (rightPressed),
    .upPressed    (upPressed),
    .downPressed  (downPressed),
    .collision    (collision),
    .onRope       (onRope),
    .objectHit    (objectHit),
    .HitEdgeCode  (HitEdgeCode),
    .topLeftX     (topLeftX),
    .topLeftY     (topLeftY),
    .motionState  (motionState),
    .jumpsLeft    (jumpsLeft),
    .stunned      (stunned)
  );

  typedef struct {
    int x;
    int y;
    int st;
    int jl;
    int sn;
  } expect_t;

  expect_t sb[$];

  int nChecks = 0;
  int nFails  = 0;

  // Reference model, all in fixed-point integers
  int mX, mY, mYs, mState, mJumps, mStun;
  bit mReq;

  task automatic checkVal(input string tag, input int obs, input int exp);
    nChecks++;
    if (obs != exp) begin
      nFails++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int px(input int v);
    logic [10:0] r;
    r = 11'(v >>> FP);
    return int'(r);
  endfunction

  function automatic int fall(input int v);
    return (v + GR > MF) ? MF : v + GR;
  endfunction

  task automatic modelReset();
    mX = XMIN * 0 + 280 * 64;
    mY = 185 * 64;
    mYs = 0;
    mState = 2;
    mJumps = MJ;
    mStun = 0;
    mReq = 0;
  endtask

  // One frame of the player as described by the behaviour rules; pushes the
  // outputs expected after the frame edge.
  task automatic modelStep();
    int xs, nx, ns;
    bit onLedge, didJump;
    expect_t e;
    onLedge = collision && HitEdgeCode[2] && !objectHit;
    didJump = 0;
    xs = 0;
    if (mState != 3) begin
      if (rightPressed && !leftPressed) xs = (collision && HitEdgeCode[1]) ? 0 : XS;
      if (leftPressed && !rightPressed) xs = (collision && HitEdgeCode[3]) ? 0 : -XS;
    end
    if (mState == 0) begin
      mYs = 0;
      mJumps = MJ;
      if (mReq) begin mYs = -JS; mJumps = MJ - 1; didJump = 1; end
    end else if (mState == 1) begin
      mJumps = MJ;
      mYs = upPressed ? -CS : (downPressed ? CS : 0);
    end else if (mState == 2) begin
      if (mReq && mJumps > 0) begin mYs = -JS; mJumps = mJumps - 1; didJump = 1; end
      else mYs = fall(mYs);
    end else begin
      mYs = fall(mYs);
    end
    if (collision && HitEdgeCode[0] && mYs < 0) mYs = 0;
    if (mState == 3 && mStun > 0) begin
      mStun = mStun - 1;
      ns = 3;
    end else if (objectHit && mState != 3) begin
      mStun = SF - 1;
      ns = 3;
    end else begin
      ns = onRope ? 1 : (didJump ? 2 : (onLedge ? 0 : 2));
    end
    nx = mX + xs;
    if (nx < XMIN * 64) nx = XMIN * 64;
    if (nx > XMAX * 64) nx = XMAX * 64;
    mX = nx;
    mY = mY + mYs;
    mState = ns;
    mReq = 0;
    e.x = px(mX);
    e.y = px(mY);
    e.st = mState;
    e.jl = mJumps;
    e.sn = (mState == 3) ? 1 : 0;
    sb.push_back(e);
  endtask

  task automatic setUp(input bit v);
    if (v && !upPressed) mReq = 1;
    upPressed = v;
  endtask

  task automatic tapUp();
    setUp(1'b1);
    @(negedge clk);
    setUp(1'b0);
  endtask

  task automatic doFrame(input string tag);
    expect_t e;
    @(negedge clk);
    startOfFrame = 1'b1;
    modelStep();
    @(negedge clk);
    startOfFrame = 1'b0;
    e = sb.pop_front();
    checkVal({tag, "_x"},  int'(topLeftX),    e.x);
    checkVal({tag, "_y"},  int'(topLeftY),    e.y);
    checkVal({tag, "_st"}, int'(motionState), e.st);
    checkVal({tag, "_jl"}, int'(jumpsLeft),   e.jl);
    checkVal({tag, "_sn"}, int'(stunned),     e.sn);
  endtask

  task automatic doReset(input string tag);
    @(negedge clk);
    resetN = 1'b0;
    startOfFrame = 1'b0;
    leftPressed = 1'b0; rightPressed = 1'b0; upPressed = 1'b0; downPressed = 1'b0;
    collision = 1'b0; onRope = 1'b0; objectHit = 1'b0; HitEdgeCode = 4'b0000;
    #1;
    checkVal({tag, "_x"},  int'(topLeftX),    280);
    checkVal({tag, "_y"},  int'(topLeftY),    185);
    checkVal({tag, "_st"}, int'(motionState), 2);
    checkVal({tag, "_jl"}, int'(jumpsLeft),   MJ);
    checkVal({tag, "_sn"}, int'(stunned),     0);
    modelReset();
    @(negedge clk);
    resetN = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int yRef;
    int stunCount;

    // Free fall from reset, then fall-speed cap
    doReset("rst0");
    for (int i = 0; i < 10; i++) doFrame("fall");
    checkVal("fall10_y", int'(topLeftY), 193);
    for (int i = 0; i < 30; i++) doFrame("fall");
    yRef = mY;
    for (int i = 0; i < 64; i++) doFrame("fallcap");
    checkVal("fallcap_dy", int'(topLeftY), px(yRef) + 230);

    // Land on a ledge, double jump, ceiling, exhausted jumps
    doReset("rst1");
    collision = 1'b1; HitEdgeCode = 4'b0100;
    doFrame("land");
    checkVal("land_state", int'(motionState), 0);
    doFrame("ground");
    checkVal("ground_jumps", int'(jumpsLeft), 2);
    tapUp();
    doFrame("jump1");
    checkVal("jump1_state", int'(motionState), 2);
    checkVal("jump1_jumps", int'(jumpsLeft), 1);
    checkVal("jump1_y", int'(topLeftY), 180);
    collision = 1'b0; HitEdgeCode = 4'b0000;
    tapUp();
    doFrame("jump2");
    checkVal("jump2_jumps", int'(jumpsLeft), 0);
    checkVal("jump2_y", int'(topLeftY), 175);
    collision = 1'b1; HitEdgeCode = 4'b0001;
    doFrame("ceil");
    checkVal("ceil_y", int'(topLeftY), 175);
    collision = 1'b0; HitEdgeCode = 4'b0000;
    for (int i = 0; i < 30; i++) doFrame("drift");
    tapUp();
    doFrame("jump3");
    checkVal("jump3_jumps", int'(jumpsLeft), 0);
    checkVal("jump3_state", int'(motionState), 2);
    setUp(1'b1);
    for (int i = 0; i < 3; i++) doFrame("held");
    setUp(1'b0);

    // Walking: right clamp, both keys, walls, left clamp
    doReset("rst2");
    collision = 1'b1; HitEdgeCode = 4'b0100;
    rightPressed = 1'b1;
    for (int i = 0; i < 100; i++) doFrame("walkr");
    checkVal("walkr_clamp", int'(topLeftX), 570);
    leftPressed = 1'b1;
    for (int i = 0; i < 5; i++) doFrame("both");
    checkVal("both_x", int'(topLeftX), 570);
    rightPressed = 1'b0;
    HitEdgeCode = 4'b1100;
    for (int i = 0; i < 3; i++) doFrame("wall_l");
    checkVal("wall_l_x", int'(topLeftX), 570);
    HitEdgeCode = 4'b0100;
    for (int i = 0; i < 190; i++) doFrame("walkl");
    checkVal("walkl_clamp", int'(topLeftX), 2039);
    leftPressed = 1'b0;
    rightPressed = 1'b1;
    HitEdgeCode = 4'b0110;
    for (int i = 0; i < 3; i++) doFrame("wall_r");
    checkVal("wall_r_x", int'(topLeftX), 2039);
    rightPressed = 1'b0;
    HitEdgeCode = 4'b0100;

    // Stun: hit once, keys ignored, second hit ignored, exact length
    objectHit = 1'b1;
    doFrame("hit");
    objectHit = 1'b0;
    rightPressed = 1'b1;
    stunCount = 0;
    for (int i = 0; i < 40; i++) begin
      if (stunned !== 1'b1) break;
      stunCount++;
      checkVal("stun_x", int'(topLeftX), 2039);
      if (i == 5) tapUp();
      objectHit = (i == 10);
      doFrame("stun");
    end
    objectHit = 1'b0;
    checkVal("stun_len", stunCount, SF);
    checkVal("stun_exit_state", int'(motionState), 0);
    checkVal("stun_exit_jumps", int'(jumpsLeft), 2);
    doFrame("afterstun");

    // Reset in the middle of a stun
    rightPressed = 1'b0;
    objectHit = 1'b1;
    doFrame("hit2");
    objectHit = 1'b0;
    for (int i = 0; i < 5; i++) doFrame("stun2");
    doReset("rst_midstun");
    doFrame("post_rst");

    // Rope climbing
    doReset("rst3");
    onRope = 1'b1;
    doFrame("rope_in");
    checkVal("rope_in_state", int'(motionState), 1);
    yRef = mY;
    setUp(1'b1);
    for (int i = 0; i < 64; i++) doFrame("climb");
    checkVal("climb_dy", int'(topLeftY), px(yRef) - 100);
    setUp(1'b0);
    tapUp();
    doFrame("rope_tap");
    checkVal("rope_tap_jumps", int'(jumpsLeft), 2);
    checkVal("rope_tap_state", int'(motionState), 1);
    downPressed = 1'b1;
    for (int i = 0; i < 4; i++) doFrame("descend");
    downPressed = 1'b0;
    onRope = 1'b0;
    for (int i = 0; i < 4; i++) doFrame("offrope");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
